zv_decompressor128: RTL

//  Inverse of the 128-lane zero-value compressor. Takes a compacted LIFM line and

---
 rtl/zv_decompressor128.sv | 116 +++++++++++
 1 files changed

// File: rtl/zv_decompressor128.sv
// Zero-value decompressor: scatters a packed 128-lane LIFM/mapping-table line back
// to its original lanes using the zero mask. Two register stages with valid/ready.
module zv_decompressor128 #(
  parameter int WORD_WIDTH    = 8,
  parameter int PSUM_WIDTH    = 7,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [127:0]                              zero_mask,
  input  logic [128*WORD_WIDTH-1:0]                 lifm_comp,
  input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   mt_comp,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [128*WORD_WIDTH-1:0]                 lifm_line,
  output logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]   mt_line,
  output logic [7:0]                                out_nnz
);

  localparam int LANES = 128;
  localparam int MT_W  = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int LW    = LANES * WORD_WIDTH;
  localparam int MW    = LANES * MT_W;

  // Handshake: a side transfers when valid & ready at posedge. The whole pipe
  // advances on en; in_ready is derived only from output-side state so it never
  // depends combinationally on in_valid.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Stage 1 combinational: exclusive prefix count of nonzero lanes gives each
  // lane its source index in the packed line.
  logic [PSUM_WIDTH-1:0] src_c [LANES];
  logic [7:0]            nnz_c;

  always_comb begin
    nnz_c = '0;
    for (int i = 0; i < LANES; i++) begin
      src_c[i] = nnz_c[PSUM_WIDTH-1:0];
      nnz_c    = nnz_c + {7'd0, ~zero_mask[i]};
    end
  end

  logic                  s1_valid;
  logic [127:0]          s1_mask;
  logic [LW-1:0]         s1_lifm;
  logic [MW-1:0]         s1_mt;
  logic [PSUM_WIDTH-1:0] s1_src [LANES];
  logic [7:0]            s1_nnz;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
    end
  end

  // Data registers need no reset: they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      s1_mask <= zero_mask;
      s1_lifm <= lifm_comp;
      s1_mt   <= mt_comp;
      s1_nnz  <= nnz_c;
      for (int i = 0; i < LANES; i++) begin
        s1_src[i] <= src_c[i];
      end
    end
  end

  // Stage 2 combinational: gather packed entries into their original lanes.
  logic [WORD_WIDTH-1:0] comp_w [LANES];
  logic [MT_W-1:0]       comp_t [LANES];
  logic [LW-1:0]         lifm_d;
  logic [MW-1:0]         mt_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      comp_w[i] = s1_lifm[i*WORD_WIDTH +: WORD_WIDTH];
      comp_t[i] = s1_mt[i*MT_W +: MT_W];
    end
  end

  always_comb begin
    lifm_d = '0;
    mt_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!s1_mask[i]) begin
        lifm_d[i*WORD_WIDTH +: WORD_WIDTH] = comp_w[s1_src[i]];
        mt_d[i*MT_W +: MT_W]               = comp_t[s1_src[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      lifm_line <= '0;
      mt_line   <= '0;
      out_nnz   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        lifm_line <= lifm_d;
        mt_line   <= mt_d;
        out_nnz   <= s1_nnz;
      end
    end
  end

endmodule
